ece571f23_g5_aes_shiftrows_pipe: RTL
====================================

# ece571f23_g5_aes_shiftrows_pipe

Parametrised, registered ShiftRows/InvShiftRows stage for the Rijndael datapath, supporting block widths of 4, 6 or 8 columns. A per-transfer mode bit selects the forward or inverse transform. A valid/ready handshake with a two-entry skid buffer lets the stage sit between the SubBytes and MixColumns pipeline stages without combinational ready paths. It supersedes the purely combinational 128-bit ShiftRows in pipelined round datapaths.

## Interface
- NB, default 4: number of state columns; legal values are 4, 6 and 8; any other value is an elaboration error.
- W, derived as 32*NB: state width in bits.
- clk, input, 1: rising-edge clock.
- reset, input, 1: synchronous, active-high.
- in_valid, input, 1: input transfer request.
- in_ready, output, 1: stage can accept; driven directly from a register.
- in_data, input, W: state, column-major; byte k (row k%4, column k/4) at bits [W-1-8k -: 8].
- in_inv, input, 1: 0 selects ShiftRows; 1 selects InvShiftRows.
- out_valid, output, 1: output holds a transformed state.
- out_ready, input, 1: downstream accepts.
- out_data, output, W: transformed state, same byte layout as in_data.
- out_inv, output, 1: the in_inv value that travelled with this state.

## Operation
- Shift offsets per row 0..3:
  - NB=4 and NB=6: 0, 1, 2, 3.
  - NB=8: 0, 1, 3, 4.
- Forward transform: out[r][c] = in[r][(c+s_r) mod NB].
- Inverse transform: out[r][c] = in[r][(c−s_r+NB) mod NB].
- The transform is applied combinationally on the input side. Only transformed data and the mode bit are stored.
- A transfer occurs on any edge where valid and ready are both 1, on the input side or the output side respectively.
- The state machine has three states, tracked by out register valid and skid register valid:
  - EMPTY: out_valid=0, in_ready=1.
    - On an input transfer: load the out register, go to ONE.
  - ONE: out_valid=1, in_ready=1.
    - Input only: load the skid register, go to FULL.
    - Output only: go to EMPTY.
    - Input and output together: reload the out register, stay in ONE.
  - FULL: out_valid=1, in_ready=0.
    - On an output transfer: move skid to out, go to ONE.
    - in_valid is ignored in this state.
- Ordering is strictly FIFO. No state is dropped or duplicated.
- Once out_valid is asserted, out_data and out_inv stay stable until the output transfer.
- The mode can change on every transfer. Each state carries its own out_inv.

## Timing
- Reset values: out_valid=0, in_ready=1, out_data=0, out_inv=0; the skid register is cleared.
- Reset mid-operation discards all held states. in_ready is 1 on the first cycle after reset deasserts.
- Latency: a state accepted at edge N appears on out_data with out_valid=1 after edge N, i.e. one cycle.
- Throughput: one state per cycle while out_ready=1.
- A single out_ready=0 stall cycle does not drop in_ready. in_ready falls only after the second unaccepted state is captured.
- in_ready depends on neither in_valid nor out_ready in the same cycle; it is purely a register.

## Structure
- Shared package ece571f23_g5_aes_pkg holds:
  - the byte typedef;
  - the NB-indexed shift-offset function shift_amt(nb, row);
  - the legal NB list.
- The function is reused by the key-schedule and round-control blocks.
- One sub-module, ece571f23_g5_aes_shiftrows_xform, is the combinational parametrised transform: inputs data and inv, output data, generate loops over rows and columns.
- The top level contains the handshake registers and the state machine.

## Test plan
- NB=4, forward, in_data=00010203_04050607_08090a0b_0c0d0e0f -> out_data=00050a0f_04090e03_080d0207_0c01060b, one cycle later.
- NB=4, forward, in_data=d42711ae_e0bf98f1_b8b45de5_1e415230 (FIPS-197 round 1) -> d4bf5d30_e0b452ae_b84111f1_1e2798e5. The inverse of that output returns the original, with out_inv=1.
- NB=6 and NB=8, for 1000 random states with alternating in_inv -> inverse(forward(x))=x.
  - NB=8 row 2 and row 3 rotate by 3 and 4 columns, checked against a model.
- Backpressure: stream 8 states with out_ready=0 for cycles 2-5.
  - in_ready drops exactly after 2 states are buffered.
  - The output sequence equals the input order, with no loss and no duplication.
  - out_data is stable while stalled.
- Continuous flow with in_valid=out_ready=1 for 16 cycles -> 16 outputs on consecutive cycles; in_ready stays 1.
- Assert reset while in FULL -> the next cycle shows out_valid=0, in_ready=1, out_data=0; the held states never appear.

Source files
------------

// File: rtl/ece571f23_g5_aes_pkg.sv
// Shared Rijndael definitions: byte type, legal block widths, ShiftRows offsets
// and the handshake state encoding for the registered ShiftRows stage.
package ece571f23_g5_aes_pkg;

  typedef logic [7:0] byte_t;

  localparam int NB_LEGAL_N = 3;
  localparam int NB_LEGAL [NB_LEGAL_N] = '{4, 6, 8};

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } sr_state_t;

  // Rijndael row offsets: rows 2 and 3 move one column further for 256-bit blocks.
  function automatic int shift_amt(input int nb, input int row);
    if (nb == 8 && row >= 2) return row + 1;
    return row;
  endfunction

  function automatic bit nb_is_legal(input int nb);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < NB_LEGAL_N; i++) begin
      if (NB_LEGAL[i] == nb) ok = 1'b1;
    end
    return ok;
  endfunction

endpackage

// File: rtl/ece571f23_g5_aes_shiftrows_xform.sv
// Combinational ShiftRows / InvShiftRows over NB columns; byte k sits at
// row k%4, column k/4, most significant byte first.
module ece571f23_g5_aes_shiftrows_xform
  import ece571f23_g5_aes_pkg::*;
#(
  parameter  int NB = 4,
  localparam int W  = 32 * NB
) (
  input  logic [W-1:0] state,
  input  logic         inv,
  output logic [W-1:0] shifted
);

  for (genvar r = 0; r < 4; r++) begin : g_row
    localparam int S = shift_amt(NB, r);
    for (genvar c = 0; c < NB; c++) begin : g_col
      localparam int CF = (c + S) % NB;
      localparam int CI = (c - S + NB) % NB;
      byte_t fwd_b;
      byte_t inv_b;
      assign fwd_b = state[W-1-8*(4*CF+r) -: 8];
      assign inv_b = state[W-1-8*(4*CI+r) -: 8];
      assign shifted[W-1-8*(4*c+r) -: 8] = inv ? inv_b : fwd_b;
    end
  end

endmodule

// File: rtl/ece571f23_g5_aes_shiftrows_pipe.sv
// Registered ShiftRows stage with a two-entry skid buffer; the transform is
// applied before capture so only shifted states and their mode bit are held.
module ece571f23_g5_aes_shiftrows_pipe
  import ece571f23_g5_aes_pkg::*;
#(
  parameter  int NB = 4,
  localparam int W  = 32 * NB
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_inv
);

  if (!nb_is_legal(NB)) begin : g_bad_nb
    $error("ece571f23_g5_aes_shiftrows_pipe: NB must be 4, 6 or 8");
  end

  sr_state_t      state_q;
  sr_state_t      state_d;
  logic           in_ready_q;
  logic           out_vld_p1;
  logic [W-1:0]   xf_data_p0;
  logic [W-1:0]   out_data_p1;
  logic           out_inv_p1;
  logic [W-1:0]   skid_data_p1;
  logic           skid_inv_p1;
  logic           in_fire;
  logic           out_fire;
  logic           load_out;
  logic           load_skid;
  logic           move_skid;

  ece571f23_g5_aes_shiftrows_xform #(.NB(NB)) u_xform (
    .state   (in_data),
    .inv     (in_inv),
    .shifted (xf_data_p0)
  );

  assign in_fire  = in_valid && in_ready_q;
  assign out_fire = out_vld_p1 && out_ready;

  always_comb begin
    state_d   = state_q;
    load_out  = 1'b0;
    load_skid = 1'b0;
    move_skid = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          load_out = 1'b1;
          state_d  = ST_ONE;
        end
      end
      ST_ONE: begin
        if (in_fire && out_fire) begin
          load_out = 1'b1;
        end else if (in_fire) begin
          load_skid = 1'b1;
          state_d   = ST_FULL;
        end else if (out_fire) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_fire) begin
          move_skid = 1'b1;
          state_d   = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // p0 -> p1: capture shifted state into the output or skid register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_EMPTY;
      in_ready_q   <= 1'b1;
      out_vld_p1   <= 1'b0;
      out_data_p1  <= '0;
      out_inv_p1   <= 1'b0;
      skid_data_p1 <= '0;
      skid_inv_p1  <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != ST_FULL);
      out_vld_p1 <= (state_d != ST_EMPTY);
      if (load_out) begin
        out_data_p1 <= xf_data_p0;
        out_inv_p1  <= in_inv;
      end else if (move_skid) begin
        out_data_p1 <= skid_data_p1;
        out_inv_p1  <= skid_inv_p1;
      end
      if (load_skid) begin
        skid_data_p1 <= xf_data_p0;
        skid_inv_p1  <= in_inv;
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_vld_p1;
  assign out_data  = out_data_p1;
  assign out_inv   = out_inv_p1;

endmodule
